// File: rtl/cp0_ctrl.sv
// MIPS CP0: Count/Compare timer, Status/Cause/EPC/PRId, interrupt masking, exception entry and ERET.
// Reads are combinational, state updates land on the next edge; no flow control, every input is consumed the cycle it is presented.
module cp0_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID       = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4:0]            RegIdx,
  input  logic [31:0]           DataIn,
  input  logic                  CP0Write,
  output logic [31:0]           DataOut,
  input  logic                  Exception,
  input  logic [4:0]            ExcCode,
  input  logic [31:0]           ExcPC,
  input  logic                  InDelaySlot,
  input  logic                  Eret,
  input  logic [NUM_HW_INT-1:0] HwInt,
  output logic [31:0]           EPC,
  output logic                  IntReq,
  output logic                  ExlOut
);

  localparam logic [4:0] IDX_COUNT   = 5'd9;
  localparam logic [4:0] IDX_COMPARE = 5'd11;
  localparam logic [4:0] IDX_STATUS  = 5'd12;
  localparam logic [4:0] IDX_CAUSE   = 5'd13;
  localparam logic [4:0] IDX_EPC     = 5'd14;
  localparam logic [4:0] IDX_PRID    = 5'd15;
  localparam logic [3:0] PRESC_LAST  = 4'(COUNT_DIV - 1);

  logic [3:0]            presc;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [31:0]           epc_q;
  logic [7:0]            im;
  logic                  exl;
  logic                  ie;
  logic                  bd;
  logic                  ti;
  logic [1:0]            ip_sw;
  logic [NUM_HW_INT-1:0] hw_q;
  logic [4:0]            exc_code;

  logic        tick;
  logic [31:0] count_inc;
  logic [7:0]  ip;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign tick       = (presc == PRESC_LAST);
  assign count_inc  = count + 32'd1;
  assign wr_count   = CP0Write && (RegIdx == IDX_COUNT);
  assign wr_compare = CP0Write && (RegIdx == IDX_COMPARE);
  assign wr_status  = CP0Write && (RegIdx == IDX_STATUS);
  assign wr_cause   = CP0Write && (RegIdx == IDX_CAUSE);
  assign wr_epc     = CP0Write && (RegIdx == IDX_EPC);

  // Timer interrupt shares the top IP bit with the highest hardware line.
  always_comb begin
    ip                    = 8'h00;
    ip[1:0]               = ip_sw;
    ip[2 +: NUM_HW_INT]   = hw_q;
    ip[7]                 = ip[7] | ti;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc    <= 4'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      epc_q    <= 32'd0;
      im       <= 8'h00;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_sw    <= 2'b00;
      hw_q     <= '0;
      exc_code <= 5'd0;
    end else begin
      hw_q <= HwInt;

      if (wr_count) begin
        count <= DataIn;
        presc <= 4'd0;
      end else begin
        presc <= tick ? 4'd0 : presc + 4'd1;
        if (tick)
          count <= count_inc;
      end

      if (wr_compare) begin
        compare <= DataIn;
        ti      <= 1'b0;
      end else if (tick && !wr_count && (count_inc == compare)) begin
        ti <= 1'b1;
      end

      if (wr_status) begin
        im  <= DataIn[15:8];
        exl <= DataIn[1];
        ie  <= DataIn[0];
      end

      if (wr_cause)
        ip_sw <= DataIn[9:8];

      // Later assignments take precedence: exception over ERET over MTC0.
      if (wr_epc && !Exception)
        epc_q <= DataIn;

      if (Exception) begin
        exl      <= 1'b1;
        exc_code <= ExcCode;
        if (!exl) begin
          epc_q <= InDelaySlot ? ExcPC - 32'd4 : ExcPC;
          bd    <= InDelaySlot;
        end
      end else if (Eret) begin
        exl <= 1'b0;
      end
    end
  end

  always_comb begin
    DataOut = 32'd0;
    case (RegIdx)
      IDX_COUNT:   DataOut = count;
      IDX_COMPARE: DataOut = compare;
      IDX_STATUS:  DataOut = {16'd0, im, 6'd0, exl, ie};
      IDX_CAUSE:   DataOut = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
      IDX_EPC:     DataOut = epc_q;
      IDX_PRID:    DataOut = PRID;
      default:     DataOut = 32'd0;
    endcase
  end

  assign EPC    = epc_q;
  assign ExlOut = exl;
  assign IntReq = ie & ~exl & (|(ip & im));

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: stimulus queues expected values, a negedge monitor pops and compares.
module tb_cp0_ctrl;
  localparam logic [31:0] PRID_VAL = 32'h0001_8000;

  logic        Clk;
  logic        Reset;
  logic [4:0]  RegIdx;
  logic [31:0] DataIn;
  logic        CP0Write;
  logic [31:0] DataOut;
  logic        Exception;
  logic [4:0]  ExcCode;
  logic [31:0] ExcPC;
  logic        InDelaySlot;
  logic        Eret;
  logic [5:0]  HwInt;
  logic [31:0] EPC;
  logic        IntReq;
  logic        ExlOut;

  cp0_ctrl #(.NUM_HW_INT(6), .COUNT_DIV(2), .PRID(PRID_VAL)) dut (
    .Clk(Clk), .Reset(Reset), .RegIdx(RegIdx), .DataIn(DataIn), .CP0Write(CP0Write),
    .DataOut(DataOut), .Exception(Exception), .ExcCode(ExcCode), .ExcPC(ExcPC),
    .InDelaySlot(InDelaySlot), .Eret(Eret), .HwInt(HwInt), .EPC(EPC),
    .IntReq(IntReq), .ExlOut(ExlOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // kind: 0 = DataOut at RegIdx, 1 = EPC, 2 = IntReq, 3 = ExlOut
  int          kind_q[$];
  logic [31:0] val_q[$];
  string       name_q[$];
  logic        chk_vld;
  int          n_chk;
  int          n_fail;

  always @(negedge Clk) begin
    if (chk_vld) begin
      if (kind_q.size() == 0) begin
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_empty: got check strobe, required a queued expectation");
      end else begin
        int          k;
        logic [31:0] exp_v;
        logic [31:0] act;
        string       nm;
        k     = kind_q.pop_front();
        exp_v = val_q.pop_front();
        nm    = name_q.pop_front();
        case (k)
          0:       act = DataOut;
          1:       act = EPC;
          2:       act = {31'd0, IntReq};
          default: act = {31'd0, ExlOut};
        endcase
        n_chk = n_chk + 1;
        if (act !== exp_v) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: actual %08h required %08h", nm, act, exp_v);
        end
      end
    end
  end

  // Each chk observes the state left by the previous edge and then consumes one edge.
  task automatic chk(input int kind, input logic [4:0] idx, input logic [31:0] val, input string name);
    if (kind == 0) RegIdx = idx;
    kind_q.push_back(kind);
    val_q.push_back(val);
    name_q.push_back(name);
    chk_vld = 1'b1;
    @(negedge Clk);
    #1 chk_vld = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    RegIdx   = idx;
    DataIn   = data;
    CP0Write = 1'b1;
    @(posedge Clk);
    #1 CP0Write = 1'b0;
  endtask

  task automatic exc(input logic [31:0] pc, input logic ds, input logic [4:0] code, input logic er);
    Exception   = 1'b1;
    ExcPC       = pc;
    InDelaySlot = ds;
    ExcCode     = code;
    Eret        = er;
    @(posedge Clk);
    #1;
    Exception   = 1'b0;
    Eret        = 1'b0;
    InDelaySlot = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_vld = 1'b0;
    Reset = 1'b1; RegIdx = 5'd0; DataIn = 32'd0; CP0Write = 1'b0;
    Exception = 1'b0; ExcCode = 5'd0; ExcPC = 32'd0; InDelaySlot = 1'b0;
    Eret = 1'b0; HwInt = 6'd0;
    cyc(2);

    // Reset state, Reset still held
    chk(0, 5'd9,  32'd0,    "rst_count");
    chk(0, 5'd12, 32'd0,    "rst_status");
    chk(0, 5'd13, 32'd0,    "rst_cause");
    chk(1, 5'd0,  32'd0,    "rst_epc");
    chk(2, 5'd0,  32'd0,    "rst_intreq");
    chk(3, 5'd0,  32'd0,    "rst_exl");
    chk(0, 5'd15, PRID_VAL, "prid");
    Reset = 1'b0;

    // Timer: Compare=5 at edge 1, Status IE|IM7 at edge 2; Count ticks on even edges
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    cyc(7);
    chk(0, 5'd9,  32'd4,          "count_before_match");
    chk(0, 5'd9,  32'd5,          "count_at_10");
    chk(0, 5'd13, 32'h4000_8000,  "cause_ti_set");
    chk(2, 5'd0,  32'd1,          "intreq_timer");
    wr(5'd12, 32'h0000_8000);
    chk(2, 5'd0,  32'd0,          "intreq_ie_off");
    wr(5'd12, 32'h0000_8001);
    chk(2, 5'd0,  32'd1,          "intreq_ie_on");

    // Compare rewrite clears TI
    wr(5'd11, 32'd100);
    chk(0, 5'd13, 32'd0,          "cause_ti_cleared");
    chk(2, 5'd0,  32'd0,          "intreq_ti_cleared");

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    chk(0, 5'd9,  32'hFFFF_FFFF,  "count_loaded");
    chk(0, 5'd9,  32'hFFFF_FFFF,  "count_presc_cleared");
    chk(0, 5'd9,  32'd0,          "count_wrap");

    // Exception in delay slot
    exc(32'h0040_0010, 1'b1, 5'd8, 1'b0);
    chk(1, 5'd0,  32'h0040_000C,  "epc_delay_slot");
    chk(0, 5'd13, 32'h8000_0020,  "cause_bd_exccode8");
    chk(0, 5'd12, 32'h0000_8003,  "status_exl_set");
    chk(3, 5'd0,  32'd1,          "exl_out_set");

    // Nested exception: EPC/BD hold, ExcCode updates
    exc(32'h0040_0100, 1'b0, 5'd12, 1'b0);
    chk(1, 5'd0,  32'h0040_000C,  "epc_hold_nested");
    chk(0, 5'd13, 32'h8000_0030,  "cause_exccode12");

    // Exception wins over Eret, then Eret alone
    exc(32'h0040_0200, 1'b0, 5'd12, 1'b1);
    chk(3, 5'd0,  32'd1,          "exl_exc_over_eret");
    Eret = 1'b1;
    cyc(1);
    Eret = 1'b0;
    chk(3, 5'd0,  32'd0,          "exl_eret");
    chk(1, 5'd0,  32'h0040_000C,  "epc_after_eret");

    // Status MTC0 in an exception cycle: IM/IE from write, EXL from exception
    RegIdx = 5'd12; DataIn = 32'h0000_FF00; CP0Write = 1'b1;
    exc(32'h0000_0100, 1'b0, 5'd4, 1'b0);
    CP0Write = 1'b0;
    chk(0, 5'd12, 32'h0000_FF02,  "status_write_with_exc");
    chk(1, 5'd0,  32'h0000_0100,  "epc_no_delay_slot");
    Eret = 1'b1;
    cyc(1);
    Eret = 1'b0;

    // Hardware interrupt: one clock of latency
    wr(5'd12, 32'h0000_0401);
    HwInt = 6'b000001;
    chk(2, 5'd0,  32'd0,          "intreq_hw_latency");
    chk(2, 5'd0,  32'd1,          "intreq_hw");
    chk(0, 5'd13, 32'h0000_0410,  "cause_ip2");
    HwInt = 6'b000000;

    // Only software IP bits are writable in Cause
    wr(5'd13, 32'hFFFF_FFFF);
    chk(0, 5'd13, 32'h0000_0310,  "cause_sw_only");
    wr(5'd8, 32'h1234_5678);
    chk(0, 5'd8,  32'd0,          "unimpl_reads_zero");

    // Reset mid-operation
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    chk(0, 5'd9,  32'd0,          "midrst_count");
    chk(0, 5'd13, 32'd0,          "midrst_cause");
    chk(0, 5'd12, 32'd0,          "midrst_status");
    chk(1, 5'd0,  32'd0,          "midrst_epc");

    cyc(2);
    if (kind_q.size() != 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", kind_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
